// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle for the sprite DMA sequencer: CPU bus snoop, source memory port,
// PPU register port and status. The master side is the DMA controller.
interface oam_dma_ctrl_if;

    // CPU bus snoop and source memory return data
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  mem_rdata;

    // CPU halt and bus ownership
    logic        cpu_rdy;
    logic        dma_active;

    // Source memory read port
    logic [15:0] dma_addr;
    logic        dma_rd;

    // PPU register port
    logic        ppu_cs_n;
    logic        ppu_we;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_wdata;

    // Completion pulse
    logic        dma_done;

    modport master (
        input  cpu_ce,
        input  cpu_addr,
        input  cpu_wr,
        input  cpu_wdata,
        input  mem_rdata,
        output cpu_rdy,
        output dma_active,
        output dma_addr,
        output dma_rd,
        output ppu_cs_n,
        output ppu_we,
        output ppu_reg_addr,
        output ppu_wdata,
        output dma_done
    );

    modport slave (
        output cpu_ce,
        output cpu_addr,
        output cpu_wr,
        output cpu_wdata,
        output mem_rdata,
        input  cpu_rdy,
        input  dma_active,
        input  dma_addr,
        input  dma_rd,
        input  ppu_cs_n,
        input  ppu_we,
        input  ppu_reg_addr,
        input  ppu_wdata,
        input  dma_done
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer. A CPU write to DMA_REG_ADDR latches a source page, halts
// the CPU and copies XFER_LEN bytes from {page, idx} into OAM through OAMDATA.
// All outputs come from flops; strobes are one clk wide per CPU cycle.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [2:0]  OAM_REG_SEL  = 3'd4,
    parameter int unsigned XFER_LEN     = 256
) (
    input  logic           clk,
    input  logic           reset,
    oam_dma_ctrl_if.master bus
);

    // XFER_LEN is a power of two, so LEN-1 is both the wrap mask and the last index.
    localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic        parity_q, parity_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        rd_stb_q, rd_stb_d;
    logic        wr_stb_q, wr_stb_d;
    logic        done_q, done_d;

    logic        trigger;
    logic        last_byte;

    assign trigger   = bus.cpu_wr && (bus.cpu_addr == DMA_REG_ADDR);
    assign last_byte = (idx_q == IDX_LAST);

    // State and datapath registers; reset aborts any transfer in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            page_q   <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            done_q   <= done_d;
        end
    end

    // Next state: advance only on CPU-cycle edges; triggers outside IDLE are ignored.
    always_comb begin
        state_d = state_q;
        if (bus.cpu_ce) begin
            unique case (state_q)
                ST_IDLE:  if (trigger) state_d = ST_HALT;
                ST_HALT:  state_d = parity_q ? ST_ALIGN : ST_READ;
                ST_ALIGN: state_d = ST_READ;
                ST_READ:  state_d = ST_WRITE;
                ST_WRITE: state_d = last_byte ? ST_IDLE : ST_READ;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: page/idx capture and advance, read-data latch, parity, and the
    // registered strobes. Strobes are set only on the CPU-cycle edge entering
    // READ/WRITE so they last one clk even when cpu_ce is sparse.
    always_comb begin
        parity_d = parity_q;
        page_d   = page_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
        done_d   = 1'b0;
        if (bus.cpu_ce) begin
            parity_d = ~parity_q;
            rd_stb_d = (state_d == ST_READ);
            wr_stb_d = (state_d == ST_WRITE);
            unique case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        page_d = bus.cpu_wdata;
                        idx_d  = '0;
                    end
                end
                ST_READ: begin
                    data_d = bus.mem_rdata;
                end
                ST_WRITE: begin
                    idx_d  = (idx_q + 8'd1) & IDX_LAST;
                    done_d = last_byte;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.cpu_rdy      = (state_q == ST_IDLE);
        bus.dma_active   = (state_q != ST_IDLE);
        bus.dma_addr     = {page_q, idx_q};
        bus.dma_rd       = rd_stb_q;
        bus.ppu_cs_n     = ~wr_stb_q;
        bus.ppu_we       = wr_stb_q;
        bus.ppu_reg_addr = (state_q == ST_WRITE) ? OAM_REG_SEL : '0;
        bus.ppu_wdata    = (state_q == ST_WRITE) ? data_q : '0;
        bus.dma_done     = done_q;
    end

endmodule
